l2_responder: RTL and testbench

//  L2-side responder for the L1 cache controller's miss and writeback requests.
//  - Accepts one read_l2 / write_l2 request at a time.
//  - Models L2 access latency with a counter FSM, then returns a one-cycle l2_ack.
//  - Backing store: DEPTH words. Read data returns with the ack.
//  - Sits between the L1 cache controller and the memory model. Serves as both

---
 rtl/l2_responder_if.sv | 42 ++++
 rtl/l2_responder.sv | 147 ++++++++++++++
 tb/tb_l2_responder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_responder_if.sv
// Request/response bundle between an L1 cache controller (master) and the
// L2 responder (slave). The master raises read_l2 / write_l2 as levels and
// holds them until it sees the one-cycle l2_ack.
interface l2_responder_if #(
  parameter int DATA_W = 32
);

  // Request side, driven by the L1 controller
  logic              read_l2;
  logic              write_l2;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;

  // Response side, driven by the L2 responder
  logic              l2_ack;
  logic              resp_wr;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output read_l2,
    output write_l2,
    output addr,
    output wdata,
    input  l2_ack,
    input  resp_wr,
    input  rdata,
    input  busy
  );

  modport slave (
    input  read_l2,
    input  write_l2,
    input  addr,
    input  wdata,
    output l2_ack,
    output resp_wr,
    output rdata,
    output busy
  );

endinterface

// File: rtl/l2_responder.sv
// L2-side responder for L1 miss fills and dirty writebacks.
// One request is served at a time: it is accepted in IDLE, waits LATENCY
// cycles in WAIT, touches the backing store on the WAIT->ACK edge, and then
// signals completion with a single-cycle l2_ack in ACK.
module l2_responder #(
  parameter int DATA_W   = 32,
  parameter int MEM_AW   = 10,
  parameter int ADDR_LSB = 2,
  parameter int LATENCY  = 4     // 1..255 cycles spent in WAIT
) (
  input  logic        clk,
  input  logic        rst,
  l2_responder_if.slave bus,
  output logic [15:0] rd_cnt_o,
  output logic [15:0] wr_cnt_o
);

  localparam int DEPTH = 1 << MEM_AW;

  // FSM encoding kept as plain constants so the state register is a vector
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  // WAIT counts from LATENCY-1 down to 0 inclusive, i.e. LATENCY cycles
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  // Address bits that actually select a word; everything else aliases
  localparam logic [31:0] IDX_MASK = 32'(((64'd1 << MEM_AW) - 64'd1) << ADDR_LSB);

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              op_q, op_d;          // 1 = write, 0 = read
  logic [MEM_AW-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q;
  logic [15:0]       rd_cnt_q, rd_cnt_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;

  // Single-cycle strobe on the WAIT->ACK edge: the moment the access happens
  logic              done;
  logic              mem_we;
  logic              rd_done;

  logic [DATA_W-1:0] mem [DEPTH];

  // The high and low address bits are intentionally ignored (aliasing)
  logic              addr_unused;
  assign addr_unused = ^(bus.addr & ~IDX_MASK);

  // Next-state logic: accept in IDLE, count down in WAIT, one cycle of ACK
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.read_l2 || bus.write_l2) begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
          // A writeback must land before a fill of the same line is served,
          // so the write wins when both are raised together.
          op_d    = bus.write_l2;
          idx_d   = bus.addr[ADDR_LSB +: MEM_AW];
          wdata_d = bus.wdata;
        end
      end
      S_WAIT: begin
        // Request inputs are deliberately not looked at here; the latched
        // copy defines the transaction even if the requester lets go.
        if (cnt_q == 8'd0) begin
          state_d = S_ACK;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Completion counters, saturating so a long run never wraps to zero
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (done && !op_q && (rd_cnt_q != 16'hFFFF)) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end
    if (done && op_q && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  // A reset landing on the completion edge must discard the write
  assign mem_we  = done && op_q && !rst;
  assign rd_done = done && !op_q;

  // Backing store write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Control and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      op_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      // Registered read: data appears together with the ack and then holds
      if (rd_done) begin
        rdata_q <= mem[idx_q];
      end
    end
  end

  // Outputs decode directly from the state register, so they are glitch-free
  assign bus.l2_ack  = (state_q == S_ACK);
  assign bus.resp_wr = (state_q == S_ACK) && op_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.rdata   = rdata_q;
  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;

endmodule

// File: tb/tb_l2_responder.sv
// Directed bench for l2_responder (LATENCY = 4). Inputs change on the falling
// edge and outputs are sampled on the falling edge, so every rising edge sees
// stable stimulus. "n" below counts falling edges after the request is driven;
// the ack of a request accepted at rising edge E0 is seen at n = LATENCY+1.
module tb_l2_responder;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  int compared;
  int mismatched;

  l2_responder_if #(.DATA_W(32)) bus ();

  l2_responder #(
    .DATA_W  (32),
    .MEM_AW  (10),
    .ADDR_LSB(2),
    .LATENCY (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .rd_cnt_o(rd_cnt),
    .wr_cnt_o(wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [15:0] exp_rd_cnt;
    logic [15:0] exp_wr_cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Bounded wait for the ack; returns -1 if it never came
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.l2_ack !== 1'b1 && n < 40);
    if (bus.l2_ack !== 1'b1) n = -1;
  endtask

  // One complete held-request transaction, checked at the ack
  task automatic req(input string name, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata,
                     input logic [15:0] exp_rd_cnt, input logic [15:0] exp_wr_cnt);
    int n;
    bus.read_l2  = rd;
    bus.write_l2 = wr;
    bus.addr     = addr;
    bus.wdata    = wdata;
    wait_ack(n);
    chk({name, "_ack_latency"}, n, LAT + 1);
    chk({name, "_resp_wr"}, {31'd0, bus.resp_wr}, {31'd0, wr});
    if (!wr) chk({name, "_rdata"}, bus.rdata, exp_rdata);
    chk({name, "_rd_cnt"}, {16'd0, rd_cnt}, {16'd0, exp_rd_cnt});
    chk({name, "_wr_cnt"}, {16'd0, wr_cnt}, {16'd0, exp_wr_cnt});
    bus.read_l2  = 1'b0;
    bus.write_l2 = 1'b0;
    @(negedge clk);
    chk({name, "_ack_one_cycle"}, {31'd0, bus.l2_ack}, 32'd0);
    $display("txn %s rd=%0b wr=%0b addr=%h wdata=%h rdata=%h rd_cnt=%0d wr_cnt=%0d",
             name, rd, wr, addr, wdata, bus.rdata, rd_cnt, wr_cnt);
  endtask

  // Both requests raised on the same address: write first, then the held read.
  // The read is accepted at the end of the IDLE cycle after ACK, so its ack
  // follows the write ack by LAT+2 cycles.
  task automatic both_seq(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [15:0] exp_rd_cnt, input logic [15:0] exp_wr_cnt);
    int n;
    bus.read_l2  = 1'b1;
    bus.write_l2 = 1'b1;
    bus.addr     = addr;
    bus.wdata    = wdata;
    wait_ack(n);
    chk({name, "_wr_ack_latency"}, n, LAT + 1);
    chk({name, "_wr_resp_wr"}, {31'd0, bus.resp_wr}, 32'd1);
    chk({name, "_wr_cnt"}, {16'd0, wr_cnt}, {16'd0, exp_wr_cnt});
    $display("txn %s write half addr=%h wdata=%h wr_cnt=%0d", name, addr, wdata, wr_cnt);
    bus.write_l2 = 1'b0;
    wait_ack(n);
    chk({name, "_rd_ack_latency"}, n, LAT + 2);
    chk({name, "_rd_resp_wr"}, {31'd0, bus.resp_wr}, 32'd0);
    chk({name, "_rd_rdata"}, bus.rdata, wdata);
    chk({name, "_rd_cnt"}, {16'd0, rd_cnt}, {16'd0, exp_rd_cnt});
    $display("txn %s read half addr=%h rdata=%h rd_cnt=%0d", name, addr, bus.rdata, rd_cnt);
    bus.read_l2 = 1'b0;
    @(negedge clk);
    chk({name, "_ack_one_cycle"}, {31'd0, bus.l2_ack}, 32'd0);
  endtask

  initial begin
    int n;
    int acks;
    int busy_hi;

    compared   = 0;
    mismatched = 0;

    //            rd    wr    addr           wdata          exp_rdata      rd  wr
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1,  2};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 2,  2};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_1010, 32'hA5A5_A5A5, 32'h0,         2,  3};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hA5A5_A5A5, 3,  3};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,         32'hCAFE_F00D, 4,  3};
    vecs[5] = '{1'b0, 1'b1, 32'hFFFF_F014, 32'h0F0F_0F0F, 32'h0,         4,  4};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,         32'h0F0F_0F0F, 5,  4};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h8000_0001, 32'h0,         5,  5};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0FFF, 32'h0,         32'h8000_0001, 6,  5};
    vecs[9] = '{1'b1, 1'b0, 32'h1000_0010, 32'h0,         32'hA5A5_A5A5, 7,  5};

    // Reset held two cycles with both requests already raised
    rst          = 1'b1;
    bus.read_l2  = 1'b1;
    bus.write_l2 = 1'b1;
    bus.addr     = 32'h0000_0080;
    bus.wdata    = 32'hCAFE_F00D;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rst%0d_ack", c), {31'd0, bus.l2_ack}, 32'd0);
      chk($sformatf("rst%0d_busy", c), {31'd0, bus.busy}, 32'd0);
      chk($sformatf("rst%0d_rdata", c), bus.rdata, 32'd0);
      chk($sformatf("rst%0d_rd_cnt", c), {16'd0, rd_cnt}, 32'd0);
      chk($sformatf("rst%0d_wr_cnt", c), {16'd0, wr_cnt}, 32'd0);
    end
    $display("txn reset held 2 cycles ack=%0b busy=%0b rdata=%h", bus.l2_ack, bus.busy, bus.rdata);
    rst = 1'b0;
    both_seq("post_rst", 32'h0000_0080, 32'hCAFE_F00D, 16'd1, 16'd1);

    // Table of single held transactions, issued back-to-back
    for (int i = 0; i < 10; i++) begin
      req($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
          vecs[i].exp_rdata, vecs[i].exp_rd_cnt, vecs[i].exp_wr_cnt);
    end

    // Simultaneous writeback + fill
    both_seq("both", 32'h0000_0040, 32'h1234_5678, 16'd8, 16'd6);

    // Reset two cycles into a write: the write is lost, counters clear
    req("pre_wr", 1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0, 16'd8, 16'd7);
    bus.write_l2 = 1'b1;
    bus.addr     = 32'h0000_0020;
    bus.wdata    = 32'h2222_2222;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ack", {31'd0, bus.l2_ack}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_rd_cnt", {16'd0, rd_cnt}, 32'd0);
    chk("midrst_wr_cnt", {16'd0, wr_cnt}, 32'd0);
    rst          = 1'b0;
    bus.write_l2 = 1'b0;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.l2_ack === 1'b1) acks++;
    end
    chk("midrst_no_ack", acks, 0);
    $display("txn reset during write addr=%h acks_after=%0d", 32'h20, acks);
    req("post_midrst_rd", 1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h1111_1111, 16'd1, 16'd0);

    // Read request pulsed only for the accept cycle
    bus.read_l2 = 1'b1;
    bus.addr    = 32'h0000_0010;
    @(negedge clk);
    bus.read_l2 = 1'b0;
    chk("pulse_rd_busy_early", {31'd0, bus.busy}, 32'd1);
    wait_ack(n);
    if (n > 0) n++;
    chk("pulse_rd_ack_latency", n, LAT + 1);
    chk("pulse_rd_busy_at_ack", {31'd0, bus.busy}, 32'd1);
    chk("pulse_rd_rdata", bus.rdata, 32'hA5A5_A5A5);
    chk("pulse_rd_rd_cnt", {16'd0, rd_cnt}, 32'd2);
    acks = 0;
    busy_hi = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.l2_ack === 1'b1) acks++;
      if (bus.busy === 1'b1) busy_hi++;
    end
    chk("pulse_rd_extra_acks", acks, 0);
    chk("pulse_rd_busy_after", busy_hi, 0);
    $display("txn pulsed read addr=%h rdata=%h extra_acks=%0d", 32'h10, bus.rdata, acks);

    // Saturated write counter, plus a write dropped during WAIT still lands
    force dut.wr_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.wr_cnt_q;
    @(negedge clk);
    chk("sat_preload", {16'd0, wr_cnt}, 32'h0000_FFFF);
    bus.write_l2 = 1'b1;
    bus.addr     = 32'h0000_0030;
    bus.wdata    = 32'h0BAD_C0DE;
    @(negedge clk);
    bus.write_l2 = 1'b0;
    wait_ack(n);
    if (n > 0) n++;
    chk("sat_wr_ack_latency", n, LAT + 1);
    chk("sat_wr_resp_wr", {31'd0, bus.resp_wr}, 32'd1);
    chk("sat_wr_cnt", {16'd0, wr_cnt}, 32'h0000_FFFF);
    $display("txn saturating write addr=%h wdata=%h wr_cnt=%h", 32'h30, 32'h0BADC0DE, wr_cnt);
    @(negedge clk);
    req("sat_rd_back", 1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'h0BAD_C0DE, 16'd3, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
